// File: rtl/clock_period_meter.sv
// clock_period_meter
// Measures the period and high time of a slow asynchronous square wave,
// counted in i_clk cycles. The results are reported once per input period.
// The first rise after arming only starts a measurement, so a partial
// first period is never reported.

module clock_period_meter #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_sig,
  output logic [COUNT_WIDTH-1:0] o_period,
  output logic [COUNT_WIDTH-1:0] o_high_time,
  output logic                   o_valid,
  output logic                   o_overflow,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM_LOW  = 2'd1,
    ST_ARM_EDGE = 2'd2,
    ST_MEASURE  = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_hcnt;
  logic [COUNT_WIDTH-1:0] w_cnt_next;
  logic [COUNT_WIDTH-1:0] w_hcnt_next;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_quiet_low;
  logic                   w_load;
  logic                   w_ovf_set;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_prev;

  // The input counts as settled low only once the whole synchroniser chain
  // and the previous sample are low. The chain is cleared by reset, so an
  // input that is already high at reset release would otherwise look like a
  // fresh rise and arm on a partial period.
  assign w_quiet_low = (r_sync == {SYNC_STAGES{1'b0}}) & ~r_s_prev;

  // Synchroniser chain and previous-sample flop for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sync   <= {SYNC_STAGES{1'b0}};
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_s_prev <= w_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and counter-update logic. Dropping i_enable wins in every state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hcnt_next  = r_hcnt;
    w_load       = 1'b0;
    w_ovf_set    = 1'b0;
    if (!i_enable) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = CNT_ZERO;
      w_hcnt_next  = CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_ARM_LOW;
          w_cnt_next   = CNT_ZERO;
          w_hcnt_next  = CNT_ZERO;
        end
        ST_ARM_LOW: begin
          if (w_quiet_low) begin
            w_state_next = ST_ARM_EDGE;
          end else begin
            w_state_next = ST_ARM_LOW;
          end
        end
        ST_ARM_EDGE: begin
          if (w_rise) begin
            w_state_next = ST_MEASURE;
            w_cnt_next   = CNT_ONE;
            w_hcnt_next  = CNT_ONE;
          end else begin
            w_state_next = ST_ARM_EDGE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            // A rise with cnt at all-ones is still a valid full-range period.
            w_load      = 1'b1;
            w_cnt_next  = CNT_ONE;
            w_hcnt_next = CNT_ONE;
          end else if (r_cnt == CNT_MAX) begin
            // Period too long: flag it and wait for a fresh rise.
            w_ovf_set    = 1'b1;
            w_state_next = ST_ARM_EDGE;
            w_cnt_next   = CNT_ZERO;
            w_hcnt_next  = CNT_ZERO;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
            if (w_s) begin
              w_hcnt_next = r_hcnt + CNT_ONE;
            end else begin
              w_hcnt_next = r_hcnt;
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = CNT_ZERO;
          w_hcnt_next  = CNT_ZERO;
        end
      endcase
    end
  end

  // Counters and registered outputs. Results are kept across disable.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt       <= CNT_ZERO;
      r_hcnt      <= CNT_ZERO;
      o_period    <= CNT_ZERO;
      o_high_time <= CNT_ZERO;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_hcnt  <= w_hcnt_next;
      o_valid <= w_load;
      o_busy  <= (w_state_next != ST_IDLE);
      if (w_load) begin
        o_period    <= r_cnt;
        o_high_time <= r_hcnt;
        o_overflow  <= 1'b0;
      end else if (w_ovf_set) begin
        o_overflow  <= 1'b1;
      end else begin
        o_overflow  <= o_overflow;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with a 4-bit counter, so the
// overflow boundary (15 cycles) is reachable with short stimulus.

module tb_clock_period_meter;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          sig;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  int q_per[$];
  int q_hi[$];

  clock_period_meter #(
    .COUNT_WIDTH(CW),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_enable   (en),
    .i_sig      (sig),
    .o_period   (period),
    .o_high_time(high_time),
    .o_valid    (valid),
    .o_overflow (overflow),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle o_valid is high, with the reported values.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      q_per.push_back(int'(period));
      q_hi.push_back(int'(high_time));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig = 1'b1;
      step(hi);
      sig = 1'b0;
      step(lo);
    end
  endtask

  task automatic pop_check(input string tag, input int per, input int hi);
    if (q_per.size() > 0) begin
      chk({tag, "_period"}, q_per.pop_front(), per);
      chk({tag, "_high"}, q_hi.pop_front(), hi);
    end else begin
      chk({tag, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sig   = 1'b0;

    // 1. Reset with i_sig toggling, then stay disabled.
    for (int i = 0; i < 3; i++) begin
      sig = ~sig;
      step(1);
      chk("rst_period", int'(period), 0);
      chk("rst_high", int'(high_time), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sig = ~sig;
      step(1);
      chk("dis_busy", int'(busy), 0);
      chk("dis_valid", int'(valid), 0);
    end
    sig = 1'b0;
    step(3);
    chk("dis_count", q_per.size(), 0);

    // 2. 8-cycle period, 4 high: 6 rises give 5 measurements.
    en = 1'b1;
    step(3);
    chk("t2_busy", int'(busy), 1);
    wave(4, 4, 6);
    step(4);
    chk("t2_count", q_per.size(), 5);
    for (int i = 0; i < 5; i++) pop_check("t2", 8, 4);
    en = 1'b0;
    step(2);
    chk("t2_busy_off", int'(busy), 0);
    chk("t2_keep_period", int'(period), 8);

    // 3. 3 high / 7 low, then 5 high / 1 low.
    en = 1'b1;
    step(3);
    wave(3, 7, 4);
    wave(5, 1, 5);
    step(4);
    chk("t3_count", q_per.size(), 8);
    for (int i = 0; i < 4; i++) pop_check("t3a", 10, 3);
    for (int i = 0; i < 4; i++) pop_check("t3b", 6, 5);
    en = 1'b0;
    step(2);

    // 4. Overflow: one rise, then i_sig held low past 15 cycles.
    en = 1'b1;
    step(3);
    sig = 1'b1;
    step(2);
    sig = 1'b0;
    step(22);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_no_valid", q_per.size(), 0);
    chk("t4_busy", int'(busy), 1);
    wave(3, 3, 4);
    step(4);
    chk("t4_count", q_per.size(), 3);
    for (int i = 0; i < 3; i++) pop_check("t4", 6, 3);
    chk("t4_ovf_clear", int'(overflow), 0);
    en = 1'b0;
    step(2);
    // Full-range period: rise coincides with cnt == 15.
    en = 1'b1;
    step(3);
    wave(5, 10, 3);
    en = 1'b0;
    step(3);
    chk("t4_max_count", q_per.size(), 2);
    for (int i = 0; i < 2; i++) pop_check("t4_max", 15, 5);
    chk("t4_max_ovf", int'(overflow), 0);

    // 6. Disable mid-measurement, re-enable, then reset mid-measurement.
    en = 1'b1;
    step(3);
    wave(3, 5, 3);
    sig = 1'b1;
    step(2);
    en  = 1'b0;
    sig = 1'b0;
    step(6);
    chk("t6_count", q_per.size(), 2);
    for (int i = 0; i < 2; i++) pop_check("t6", 8, 3);
    chk("t6_keep_period", int'(period), 8);
    chk("t6_keep_high", int'(high_time), 3);
    chk("t6_busy", int'(busy), 0);
    en = 1'b1;
    step(3);
    wave(3, 3, 3);
    step(3);
    chk("t6_rearm_count", q_per.size(), 2);
    for (int i = 0; i < 2; i++) pop_check("t6_rearm", 6, 3);
    sig = 1'b1;
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("t6_rst_period", int'(period), 0);
    chk("t6_rst_high", int'(high_time), 0);
    chk("t6_rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    sig   = 1'b0;
    step(6);
    chk("t6_rst_count", q_per.size(), 0);

    // 5. i_sig high at reset release with i_enable=1.
    rst_n = 1'b0;
    en    = 1'b1;
    sig   = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(6);
    sig = 1'b0;
    step(4);
    chk("t5_early", q_per.size(), 0);
    wave(4, 4, 2);
    en = 1'b0;
    step(2);
    chk("t5_count", q_per.size(), 1);
    pop_check("t5", 8, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
